// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared encodings for the RV32I-subset CPU control path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation codes consumed by the datapath
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Writeback source select
    localparam logic [2:0] RES_ALU = 3'b000;
    localparam logic [2:0] RES_MEM = 3'b001;
    localparam logic [2:0] RES_PC4 = 3'b010;

    // Main decoder to ALU decoder hand-off
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // funct3 values that select a non-add operation under ALUOP_FUNCT
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       alu_select;
        logic       mem_write;
        logic [2:0] result_select;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
    } main_ctrl_t;

    localparam main_ctrl_t CTRL_NONE = '0;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
//  Module      : alu_decoder
//  Description : Maps the main decoder's ALU_op plus funct fields to ALU_control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    logic w_is_sub;

    // Only R-type (opcode[5]=1) may subtract; addi with imm[10]=1 stays an add.
    assign w_is_sub = op5_i & funct7b5_i;

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    F3_ADDSUB: alu_control_o = w_is_sub ? ALU_SUB : ALU_ADD;
                    F3_SLT:    alu_control_o = ALU_SLT;
                    F3_XOR:    alu_control_o = ALU_XOR;
                    F3_OR:     alu_control_o = ALU_OR;
                    F3_AND:    alu_control_o = ALU_AND;
                    default:   alu_control_o = ALU_ADD;
                endcase
            end
            default:   alu_control_o = ALU_ADD;
        endcase
    end

endmodule : alu_decoder

`default_nettype wire

// File: rtl/controller.sv
// ============================================================================
//  Module      : controller
//  Description : Single-cycle instruction decode controller with sticky
//                illegal-opcode fault flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [2:0] result_select,
    output logic       mem_write,
    output logic       PC_select,
    output logic       ALU_select,
    output logic       reg_write,
    output logic       jump,
    output logic [2:0] ALU_control,
    output logic       illegal_op,
    output logic       fault
);

    main_ctrl_t w_ctrl;
    logic       w_illegal;
    logic       fault_q;
    logic       fault_d;

    // Main decode: unsupported opcodes yield an all-zero control word.
    always_comb begin
        w_ctrl    = CTRL_NONE;
        w_illegal = 1'b0;
        case (opcode)
            OP_LOAD: begin
                w_ctrl.reg_write     = 1'b1;
                w_ctrl.alu_select    = 1'b1;
                w_ctrl.result_select = RES_MEM;
                w_ctrl.alu_op        = ALUOP_ADD;
            end
            OP_STORE: begin
                w_ctrl.alu_select    = 1'b1;
                w_ctrl.mem_write     = 1'b1;
                w_ctrl.alu_op        = ALUOP_ADD;
            end
            OP_R: begin
                w_ctrl.reg_write     = 1'b1;
                w_ctrl.alu_op        = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                w_ctrl.branch        = 1'b1;
                w_ctrl.alu_op        = ALUOP_SUB;
            end
            OP_I_ALU: begin
                w_ctrl.reg_write     = 1'b1;
                w_ctrl.alu_select    = 1'b1;
                w_ctrl.alu_op        = ALUOP_FUNCT;
            end
            OP_JAL: begin
                w_ctrl.reg_write     = 1'b1;
                w_ctrl.result_select = RES_PC4;
                w_ctrl.jump          = 1'b1;
            end
            default: begin
                w_ctrl    = CTRL_NONE;
                w_illegal = 1'b1;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (w_ctrl.alu_op),
        .funct3_i      (funct3),
        .op5_i         (opcode[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (ALU_control)
    );

    always_comb begin
        fault_d = fault_q;
        if (w_illegal) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign result_select = w_ctrl.result_select;
    assign mem_write     = w_ctrl.mem_write;
    assign ALU_select    = w_ctrl.alu_select;
    assign reg_write     = w_ctrl.reg_write;
    assign jump          = w_ctrl.jump;
    assign PC_select     = (w_ctrl.branch & zero) | w_ctrl.jump;
    assign illegal_op    = w_illegal;
    assign fault         = fault_q;

endmodule : controller

`default_nettype wire

// File: tb/tb_controller.sv
// ============================================================================
//  Module      : tb_controller
//  Description : Directed self-checking bench for the decode controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller;

    logic       clock;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [2:0] result_select;
    logic       mem_write;
    logic       PC_select;
    logic       ALU_select;
    logic       reg_write;
    logic       jump;
    logic [2:0] ALU_control;
    logic       illegal_op;
    logic       fault;

    int checks = 0;
    int errors = 0;

    // {reg_write, ALU_select, mem_write, result_select, jump, PC_select, illegal_op, ALU_control}
    logic [11:0] obs;
    assign obs = {reg_write, ALU_select, mem_write, result_select,
                  jump, PC_select, illegal_op, ALU_control};

    controller dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .result_select (result_select),
        .mem_write     (mem_write),
        .PC_select     (PC_select),
        .ALU_select    (ALU_select),
        .reg_write     (reg_write),
        .jump          (jump),
        .ALU_control   (ALU_control),
        .illegal_op    (illegal_op),
        .fault         (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic z);
        @(negedge clock);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        @(posedge clock); #1;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault got %b want 0", fault);
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        checks++;
        if (obs !== 12'b1_1_0_001_0_0_0_000) begin
            errors++;
            $display("FAIL lw got %b want %b", obs, 12'b1_1_0_001_0_0_0_000);
        end
    endtask

    task automatic test_sw();
        drive(7'b0100011, 3'b010, 1'b0, 1'b1);
        checks++;
        if (obs !== 12'b0_1_1_000_0_0_0_000) begin
            errors++;
            $display("FAIL sw got %b want %b", obs, 12'b0_1_1_000_0_0_0_000);
        end
    endtask

    task automatic test_rtype();
        logic [2:0] f3_v [6] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b100};
        logic       f7_v [6] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
        logic [2:0] exp_v[6] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b101, 3'b100};
        for (int i = 0; i < 6; i++) begin
            drive(7'b0110011, f3_v[i], f7_v[i], 1'b0);
            checks++;
            if (obs !== {9'b1_0_0_000_0_0_0, exp_v[i]}) begin
                errors++;
                $display("FAIL rtype_%0d got %b want %b", i, obs,
                         {9'b1_0_0_000_0_0_0, exp_v[i]});
            end
        end
    endtask

    task automatic test_beq();
        drive(7'b1100011, 3'b000, 1'b0, 1'b0);
        checks++;
        if (obs !== 12'b0_0_0_000_0_0_0_001) begin
            errors++;
            $display("FAIL beq_nz got %b want %b", obs, 12'b0_0_0_000_0_0_0_001);
        end
        drive(7'b1100011, 3'b000, 1'b0, 1'b1);
        checks++;
        if (obs !== 12'b0_0_0_000_0_1_0_001) begin
            errors++;
            $display("FAIL beq_z got %b want %b", obs, 12'b0_0_0_000_0_1_0_001);
        end
    endtask

    task automatic test_ialu();
        drive(7'b0010011, 3'b000, 1'b1, 1'b0);
        checks++;
        if (obs !== 12'b1_1_0_000_0_0_0_000) begin
            errors++;
            $display("FAIL addi got %b want %b", obs, 12'b1_1_0_000_0_0_0_000);
        end
        drive(7'b0010011, 3'b111, 1'b0, 1'b0);
        checks++;
        if (obs !== 12'b1_1_0_000_0_0_0_010) begin
            errors++;
            $display("FAIL andi got %b want %b", obs, 12'b1_1_0_000_0_0_0_010);
        end
    endtask

    task automatic test_jal();
        drive(7'b1101111, 3'b000, 1'b0, 1'b0);
        checks++;
        if (obs !== 12'b1_0_0_010_1_1_0_000) begin
            errors++;
            $display("FAIL jal got %b want %b", obs, 12'b1_0_0_010_1_1_0_000);
        end
    endtask

    task automatic test_fault();
        drive(7'b1111111, 3'b111, 1'b1, 1'b1);
        checks++;
        if (obs !== 12'b0_0_0_000_0_0_1_000 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL illegal_ff got %b want %b", obs, 12'b0_0_0_000_0_0_1_000);
        end
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_pre_edge got %b want 0", fault);
        end
        drive(7'b0000000, 3'b000, 1'b0, 1'b1);
        checks++;
        if (obs !== 12'b0_0_0_000_0_0_1_000) begin
            errors++;
            $display("FAIL illegal_00 got %b want %b", obs, 12'b0_0_0_000_0_0_1_000);
        end
        @(posedge clock); #1;
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_set got %b want 1", fault);
        end
        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        @(posedge clock); #1;
        checks++;
        if (fault !== 1'b1 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL fault_hold got %b/%b want 1/0", fault, illegal_op);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear got %b want 0", fault);
        end
        reset = 1'b1;
        drive(7'b1111111, 3'b000, 1'b0, 1'b0);
        checks++;
        if (illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL illegal_in_reset got %b want 1", illegal_op);
        end
        @(posedge clock); #1;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins got %b want 0", fault);
        end
        drive(7'b0110011, 3'b000, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_stays_clear got %b want 0", fault);
        end
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 7'b0000011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_ialu();
        test_jal();
        test_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_controller

`default_nettype wire
